// File: rtl/subf_coef_loader.sv
// subf_coef_loader: accepts one (idmean, idvar) coefficient set over a valid/ready stream,
// writes it into function_subf's RAMs, releases function_subf for a fixed latency and
// captures its result with a one-cycle valid pulse. Every output is registered.
module subf_coef_loader #(
  parameter int unsigned NUM_ELEMENTS   = 50,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RESULT_LATENCY = 54
) (
  input  logic                  clk,
  input  logic                  rst_load,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_mean,
  input  logic [DATA_WIDTH-1:0] s_var,
  input  logic                  s_last,
  output logic [5:0]            ram_idmean_in_addr,
  output logic [5:0]            ram_idvar_in_addr,
  output logic [DATA_WIDTH-1:0] ram_idmean_in,
  output logic [DATA_WIDTH-1:0] ram_idvar_in,
  output logic                  ram_idmeanvar_we,
  output logic                  rst_subf,
  input  logic [DATA_WIDTH-1:0] result_subf,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  err_len
);

  localparam logic [5:0] LastBeat = 6'(NUM_ELEMENTS - 1);
  localparam logic [6:0] LastRun  = 7'(RESULT_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StCapture} state_e;

  state_e                state_q, state_d;
  logic [5:0]            beat_cnt_q, beat_cnt_d;
  logic [6:0]            run_cnt_q, run_cnt_d;
  logic                  s_ready_q, s_ready_d;
  logic [5:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] mean_q, mean_d;
  logic [DATA_WIDTH-1:0] var_q, var_d;
  logic                  we_q, we_d;
  logic                  rst_subf_q, rst_subf_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  hs;

  // s_ready is registered, so the handshake uses the flopped value the source sees.
  assign hs = s_valid & s_ready_q;

  // Next-state and registered-output computation for the load/run/capture sequence.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    run_cnt_d  = run_cnt_q;
    s_ready_d  = s_ready_q;
    addr_d     = addr_q;
    mean_d     = mean_q;
    var_d      = var_q;
    we_d       = 1'b0;
    rst_subf_d = rst_subf_q;
    result_d   = result_q;
    valid_d    = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      StIdle, StLoad: begin
        s_ready_d  = 1'b1;
        rst_subf_d = 1'b0;
        if (hs) begin
          // beat_cnt_q is 0 in idle, so the first beat lands at address 0.
          addr_d = beat_cnt_q;
          mean_d = s_mean;
          var_d  = s_var;
          we_d   = 1'b1;
          if (state_q == StIdle) begin
            err_d = 1'b0;
          end
          if (beat_cnt_q == LastBeat) begin
            beat_cnt_d = '0;
            if (s_last) begin
              state_d   = StRun;
              s_ready_d = 1'b0;
            end else begin
              state_d = StIdle;
              err_d   = 1'b1;
            end
          end else if (s_last) begin
            // Short set: give up on it; RAM keeps whatever was written.
            beat_cnt_d = '0;
            state_d    = StIdle;
            err_d      = 1'b1;
            s_ready_d  = 1'b0;
          end else begin
            beat_cnt_d = beat_cnt_q + 6'd1;
            state_d    = StLoad;
          end
        end
      end
      StRun: begin
        s_ready_d  = 1'b0;
        rst_subf_d = 1'b1;
        if (run_cnt_q == LastRun) begin
          run_cnt_d = '0;
          state_d   = StCapture;
        end else begin
          run_cnt_d = run_cnt_q + 7'd1;
        end
      end
      StCapture: begin
        result_d   = result_subf;
        valid_d    = 1'b1;
        rst_subf_d = 1'b0;
        s_ready_d  = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset aborts any set or run immediately.
  always_ff @(posedge clk or negedge rst_load) begin
    if (!rst_load) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      run_cnt_q  <= '0;
      s_ready_q  <= 1'b0;
      addr_q     <= '0;
      mean_q     <= '0;
      var_q      <= '0;
      we_q       <= 1'b0;
      rst_subf_q <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      run_cnt_q  <= run_cnt_d;
      s_ready_q  <= s_ready_d;
      addr_q     <= addr_d;
      mean_q     <= mean_d;
      var_q      <= var_d;
      we_q       <= we_d;
      rst_subf_q <= rst_subf_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign s_ready            = s_ready_q;
  assign ram_idmean_in_addr = addr_q;
  assign ram_idvar_in_addr  = addr_q;
  assign ram_idmean_in      = mean_q;
  assign ram_idvar_in       = var_q;
  assign ram_idmeanvar_we   = we_q;
  assign rst_subf           = rst_subf_q;
  assign result_out         = result_q;
  assign result_valid       = valid_q;
  assign busy               = busy_q;
  assign err_len            = err_q;

endmodule

// File: tb/tb_subf_coef_loader.sv
// Randomized bench for subf_coef_loader with a transaction-level reference model and a
// small behavioural stand-in for function_subf that produces a per-run result.
module tb_subf_coef_loader;

  localparam int N  = 50;
  localparam int DW = 32;
  localparam int RL = 54;

  logic          clk = 1'b0;
  logic          rst_load = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_mean = '0;
  logic [DW-1:0] s_var = '0;
  logic          s_last = 1'b0;
  logic [5:0]    ram_idmean_in_addr;
  logic [5:0]    ram_idvar_in_addr;
  logic [DW-1:0] ram_idmean_in;
  logic [DW-1:0] ram_idvar_in;
  logic          ram_idmeanvar_we;
  logic          rst_subf;
  logic [DW-1:0] result_subf;
  logic [DW-1:0] result_out;
  logic          result_valid;
  logic          busy;
  logic          err_len;

  subf_coef_loader #(
    .NUM_ELEMENTS  (N),
    .DATA_WIDTH    (DW),
    .RESULT_LATENCY(RL)
  ) dut (
    .clk               (clk),
    .rst_load          (rst_load),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_mean            (s_mean),
    .s_var             (s_var),
    .s_last            (s_last),
    .ram_idmean_in_addr(ram_idmean_in_addr),
    .ram_idvar_in_addr (ram_idvar_in_addr),
    .ram_idmean_in     (ram_idmean_in),
    .ram_idvar_in      (ram_idvar_in),
    .ram_idmeanvar_we  (ram_idmeanvar_we),
    .rst_subf          (rst_subf),
    .result_subf       (result_subf),
    .result_out        (result_out),
    .result_valid      (result_valid),
    .busy              (busy),
    .err_len           (err_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] run_result(input int n);
    return 32'h9E3779B9 * 32'(n) + 32'h0BADF00D;
  endfunction

  // function_subf stand-in: output is only valid once rst_subf has been high RL cycles.
  int   cyc = 0;
  int   hi_cnt = 0;
  int   run_no = 0;
  logic rst_prev = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst_subf;
    if (rst_subf) begin
      hi_cnt <= hi_cnt + 1;
      if (!rst_prev) run_no <= run_no + 1;
    end else begin
      hi_cnt <= 0;
    end
  end
  assign result_subf = (rst_subf && hi_cnt >= RL - 1) ? run_result(run_no)
                                                      : ~run_result(run_no) ^ 32'(hi_cnt);

  // Reference model state: expected writes, current set progress, pending result.
  typedef struct {
    logic [5:0]  addr;
    logic [31:0] mean;
    logic [31:0] vr;
    int          cyc;
  } wr_t;

  wr_t         wq[$];
  bit          in_set = 0;
  bit          pend = 0;
  bit          exp_err = 0;
  bit          rdy_block = 0;
  int          beat_idx = 0;
  int          res_cycle = 0;
  int          model_run = 0;
  logic [31:0] res_val = '0;
  logic [31:0] held = '0;
  logic [5:0]  last_addr = '0;
  logic [31:0] last_mean = '0;
  logic [31:0] last_var = '0;

  // Per-cycle monitor: compare outputs to the model, then advance the model by one cycle.
  initial begin : monitor
    bit  running;
    bit  vld;
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst_load) begin
        wq.delete();
        in_set    = 0;
        pend      = 0;
        exp_err   = 0;
        rdy_block = 0;
        held      = '0;
        last_addr = '0;
        last_mean = '0;
        last_var  = '0;
      end else begin
        running = pend && cyc < res_cycle;
        check("busy", busy, in_set || running);
        check("s_ready", s_ready, !rdy_block && !running);
        check("rst_subf", rst_subf, pend && cyc >= res_cycle - RL && cyc < res_cycle);
        vld = pend && cyc == res_cycle;
        check("result_valid", result_valid, vld);
        if (vld) begin
          held = res_val;
          pend = 0;
        end
        check("result_out", result_out, held);
        check("err_len", err_len, exp_err);
        if (ram_idmeanvar_we) begin
          if (wq.size() == 0) begin
            check("we_without_handshake", ram_idmeanvar_we, 0);
          end else begin
            w = wq.pop_front();
            check("we_cycle", cyc, w.cyc);
            last_addr = w.addr;
            last_mean = w.mean;
            last_var  = w.vr;
          end
        end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
          check("we_missing", ram_idmeanvar_we, 1);
          void'(wq.pop_front());
        end
        check("idmean_addr", ram_idmean_in_addr, last_addr);
        check("idvar_addr", ram_idvar_in_addr, last_addr);
        check("idmean_data", ram_idmean_in, last_mean);
        check("idvar_data", ram_idvar_in, last_var);

        rdy_block = 0;
        if (s_valid && s_ready) begin
          if (!in_set) begin
            in_set   = 1;
            beat_idx = 0;
            exp_err  = 0;
          end
          w.addr = 6'(beat_idx);
          w.mean = s_mean;
          w.vr   = s_var;
          w.cyc  = cyc + 1;
          wq.push_back(w);
          if (s_last && beat_idx == N - 1) begin
            in_set = 0;
            pend   = 1;
            model_run++;
            res_val   = run_result(model_run);
            res_cycle = cyc + 1 + RL + 1;
          end else if (s_last) begin
            in_set    = 0;
            exp_err   = 1;
            rdy_block = 1;
          end else if (beat_idx == N - 1) begin
            in_set  = 0;
            exp_err = 1;
          end else begin
            beat_idx++;
          end
        end
      end
    end
  end

  task automatic idle(input int k);
    s_valid = 1'b0;
    s_mean  = $urandom;
    s_var   = $urandom;
    s_last  = 1'($urandom);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: continuous random, 1: valid every other cycle, 2: random gaps, 3: nominal data.
  task automatic send_set(input int n, input int last_at, input int mode);
    bit hs;
    int budget;
    for (int i = 0; i < n; i++) begin
      if (mode == 1 && i > 0) idle(1);
      else if (mode == 2) idle($urandom_range(0, 3));
      s_valid = 1'b1;
      s_mean  = (mode == 3) ? 32'(i) : $urandom;
      s_var   = (mode == 3) ? 32'h3F800000 : $urandom;
      s_last  = (i == last_at);
      hs      = 0;
      budget  = 0;
      while (!hs && budget < 200) begin
        @(negedge clk);
        hs = s_ready;
        @(posedge clk);
        #1;
        budget++;
      end
      if (!hs) begin
        check("handshake_timeout", 32'(hs), 1);
        break;
      end
    end
    idle(0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pend || in_set) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle(2);
    check("idle_busy", busy, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".s_ready"}, s_ready, 0);
    check({tag, ".we"}, ram_idmeanvar_we, 0);
    check({tag, ".idmean_addr"}, ram_idmean_in_addr, 0);
    check({tag, ".idvar_addr"}, ram_idvar_in_addr, 0);
    check({tag, ".idmean"}, ram_idmean_in, 0);
    check({tag, ".idvar"}, ram_idvar_in, 0);
    check({tag, ".rst_subf"}, rst_subf, 0);
    check({tag, ".result_out"}, result_out, 0);
    check({tag, ".result_valid"}, result_valid, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".err_len"}, err_len, 0);
  endtask

  initial begin : main
    int kind;
    int b;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    #2 rst_load = 1'b1;
    idle(3);

    // Nominal set, valid held high.
    send_set(N, N - 1, 3);
    wait_idle();
    // Valid toggling every other cycle.
    send_set(N, N - 1, 1);
    wait_idle();
    // Early s_last on beat 10, then a clean set clears the error.
    send_set(11, 10, 2);
    idle(10);
    check("err_after_early_last", err_len, 1);
    check("no_run_after_early_last", rst_subf, 0);
    send_set(N, N - 1, 2);
    wait_idle();
    check("err_cleared", err_len, 0);
    // Missing s_last on the final beat.
    send_set(N, -1, 0);
    idle(10);
    check("err_after_missing_last", err_len, 1);
    check("no_run_after_missing_last", rst_subf, 0);
    send_set(N, N - 1, 0);
    wait_idle();
    // Asynchronous reset in the middle of a run.
    send_set(N, N - 1, 0);
    repeat (20) @(posedge clk);
    check("running_before_reset", rst_subf, 1);
    #3 rst_load = 1'b0;
    #1 check_zero("reset_mid_run");
    @(negedge clk);
    @(negedge clk);
    #2 rst_load = 1'b1;
    idle(2);
    send_set(N, N - 1, 2);
    wait_idle();
    // Back-to-back sets with valid held high.
    send_set(N, N - 1, 0);
    send_set(N, N - 1, 0);
    wait_idle();
    // Random mix.
    for (int k = 0; k < 6; k++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          send_set(N, N - 1, $urandom_range(0, 2));
          wait_idle();
        end
        1: begin
          b = $urandom_range(0, N - 2);
          send_set(b + 1, b, 2);
          idle($urandom_range(1, 4));
        end
        2: begin
          send_set(N, -1, 2);
          idle($urandom_range(1, 4));
        end
        default: begin
          send_set(N, N - 1, 0);
          send_set(N, N - 1, 2);
          wait_idle();
        end
      endcase
    end
    send_set(N, N - 1, 0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
